arithmetic: RTL and testbench



---
 rtl/arithmetic_pkg.sv | 19 +
 rtl/arith_core.sv | 34 +++
 rtl/arithmetic.sv | 61 ++++++
 tb/tb_arithmetic.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arithmetic_pkg.sv
// Shared types for the arithmetic leaf: default width and the registered flag record.
// Optional signed-overflow flags are compiled in with ARITHMETIC_OVF_EN.
package arithmetic_pkg;

   localparam int ARITH_DEFAULT_WIDTH = 1;

   // Width-independent part of a result; sum/diff ride alongside at the instance width.
   typedef struct packed {
      logic carry;
      logic borrow;
`ifdef ARITHMETIC_OVF_EN
      logic ovf_add;
      logic ovf_sub;
`endif
   } arith_flags_t;

   localparam arith_flags_t ARITH_FLAGS_RST = '0;

endpackage

// File: rtl/arith_core.sv
// Combinational half-adder / half-subtractor core (sum, carry, difference, borrow).
// Signed-overflow flags are produced only when ARITHMETIC_OVF_EN is defined.
module arith_core
   import arithmetic_pkg::*;
#(
   parameter int WIDTH = ARITH_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] diff,
   output arith_flags_t     flags
);

   logic [WIDTH:0] add_full;
   logic [WIDTH:0] sub_full;

   // One extra bit on each side: its MSB is the carry or the borrow.
   assign add_full = {1'b0, a} + {1'b0, b};
   assign sub_full = {1'b0, a} - {1'b0, b};

   always_comb begin
      flags        = ARITH_FLAGS_RST;
      sum          = add_full[WIDTH-1:0];
      diff         = sub_full[WIDTH-1:0];
      flags.carry  = add_full[WIDTH];
      flags.borrow = sub_full[WIDTH];
`ifdef ARITHMETIC_OVF_EN
      flags.ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      flags.ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
`endif
   end

endmodule

// File: rtl/arithmetic.sv
// Registered half-adder / half-subtractor: one-cycle latency, results hold while in_valid is low.
// Define ARITHMETIC_OVF_EN to add the ovf_add / ovf_sub signed-overflow outputs.
module arithmetic
   import arithmetic_pkg::*;
#(
   parameter int WIDTH = ARITH_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] w,
   output logic             x,
   output logic [WIDTH-1:0] y,
`ifdef ARITHMETIC_OVF_EN
   output logic             ovf_add,
   output logic             ovf_sub,
`endif
   output logic             z
);

   logic [WIDTH-1:0] sum_n;
   logic [WIDTH-1:0] diff_n;
   arith_flags_t     flags_n;
   arith_flags_t     flags_q;

   arith_core #(.WIDTH(WIDTH)) u_core (
      .a     (a),
      .b     (b),
      .sum   (sum_n),
      .diff  (diff_n),
      .flags (flags_n)
   );

   // Results load only on a valid beat; out_valid is a one-cycle pulse per beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         w         <= '0;
         y         <= '0;
         flags_q   <= ARITH_FLAGS_RST;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            w       <= sum_n;
            y       <= diff_n;
            flags_q <= flags_n;
         end
      end
   end

   assign x = flags_q.carry;
   assign z = flags_q.borrow;
`ifdef ARITHMETIC_OVF_EN
   assign ovf_add = flags_q.ovf_add;
   assign ovf_sub = flags_q.ovf_sub;
`endif

endmodule

// File: tb/tb_arithmetic.sv
// Directed bench for arithmetic: WIDTH=1 truth table and WIDTH=8 vectors, hold and async reset.
// Overflow outputs are checked when ARITHMETIC_OVF_EN is defined.
module tb_arithmetic;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       v1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       ov1;
   logic [0:0] w1;
   logic       x1;
   logic [0:0] y1;
   logic       z1;
   logic       v8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       ov8;
   logic [7:0] w8;
   logic       x8;
   logic [7:0] y8;
   logic       z8;
`ifdef ARITHMETIC_OVF_EN
   logic oa1, os1, oa8, os8;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   arithmetic #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
      .out_valid(ov1), .w(w1), .x(x1), .y(y1),
`ifdef ARITHMETIC_OVF_EN
      .ovf_add(oa1), .ovf_sub(os1),
`endif
      .z(z1)
   );

   arithmetic #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
      .out_valid(ov8), .w(w8), .x(x8), .y(y8),
`ifdef ARITHMETIC_OVF_EN
      .ovf_add(oa8), .ovf_sub(os8),
`endif
      .z(z8)
   );

   typedef struct {
      logic [0:0] a, b, w;
      logic       x;
      logic [0:0] y;
      logic       z;
   } vec1_t;

   typedef struct {
      logic [7:0] a, b, w;
      logic       x;
      logic [7:0] y;
      logic       z;
      logic       oa, os;
   } vec8_t;

   vec1_t t1[4];
   vec8_t t8[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string tag, input vec8_t v, input logic exp_valid);
      chk({tag, ".w"}, 32'(w8), 32'(v.w));
      chk({tag, ".x"}, 32'(x8), 32'(v.x));
      chk({tag, ".y"}, 32'(y8), 32'(v.y));
      chk({tag, ".z"}, 32'(z8), 32'(v.z));
      chk({tag, ".out_valid"}, 32'(ov8), 32'(exp_valid));
`ifdef ARITHMETIC_OVF_EN
      chk({tag, ".ovf_add"}, 32'(oa8), 32'(v.oa));
      chk({tag, ".ovf_sub"}, 32'(os8), 32'(v.os));
`endif
   endtask

   // Drive one beat just after a rising edge; results are checked 1 time unit after the next edge.
   task automatic apply8(input logic [7:0] a, input logic [7:0] b, input logic vld);
      a8 = a;
      b8 = b;
      v8 = vld;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec8_t e;
      t1[0] = '{a:1'b0, b:1'b0, w:1'b0, x:1'b0, y:1'b0, z:1'b0};
      t1[1] = '{a:1'b0, b:1'b1, w:1'b1, x:1'b0, y:1'b1, z:1'b1};
      t1[2] = '{a:1'b1, b:1'b0, w:1'b1, x:1'b0, y:1'b1, z:1'b0};
      t1[3] = '{a:1'b1, b:1'b1, w:1'b0, x:1'b1, y:1'b0, z:1'b0};

      t8[0] = '{a:8'd200, b:8'd100, w:8'd44,  x:1'b1, y:8'd100, z:1'b0, oa:1'b0, os:1'b1};
      t8[1] = '{a:8'd100, b:8'd200, w:8'd44,  x:1'b1, y:8'd156, z:1'b1, oa:1'b0, os:1'b1};
      t8[2] = '{a:8'd127, b:8'd1,   w:8'd128, x:1'b0, y:8'd126, z:1'b0, oa:1'b1, os:1'b0};
      t8[3] = '{a:8'h80,  b:8'd1,   w:8'd129, x:1'b0, y:8'd127, z:1'b0, oa:1'b0, os:1'b1};
      t8[4] = '{a:8'd5,   b:8'd5,   w:8'd10,  x:1'b0, y:8'd0,   z:1'b0, oa:1'b0, os:1'b0};
      t8[5] = '{a:8'd255, b:8'd255, w:8'd254, x:1'b1, y:8'd0,   z:1'b0, oa:1'b0, os:1'b0};
      t8[6] = '{a:8'd0,   b:8'd255, w:8'd255, x:1'b0, y:8'd1,   z:1'b1, oa:1'b0, os:1'b0};

      // Reset state while rst_n is low, even across a clock edge with in_valid high.
      #2;
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
      v8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
      @(posedge clk); #1;
      e = '{a:8'd0, b:8'd0, w:8'd0, x:1'b0, y:8'd0, z:1'b0, oa:1'b0, os:1'b0};
      chk8("reset8", e, 1'b0);
      chk("reset1.w", 32'(w1), 0);
      chk("reset1.x", 32'(x1), 0);
      chk("reset1.out_valid", 32'(ov1), 0);
      v1 = 1'b0;
      v8 = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // WIDTH=1 truth table, one vector per cycle.
      for (int i = 0; i < 4; i++) begin
         a1 = t1[i].a;
         b1 = t1[i].b;
         v1 = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("tt1[%0d].w", i), 32'(w1), 32'(t1[i].w));
         chk($sformatf("tt1[%0d].x", i), 32'(x1), 32'(t1[i].x));
         chk($sformatf("tt1[%0d].y", i), 32'(y1), 32'(t1[i].y));
         chk($sformatf("tt1[%0d].z", i), 32'(z1), 32'(t1[i].z));
         chk($sformatf("tt1[%0d].out_valid", i), 32'(ov1), 1);
`ifdef ARITHMETIC_OVF_EN
         chk($sformatf("tt1[%0d].ovf_add", i), 32'(oa1), 32'(t1[i].a == t1[i].b && t1[i].w != t1[i].a));
         chk($sformatf("tt1[%0d].ovf_sub", i), 32'(os1), 32'(t1[i].a != t1[i].b && t1[i].y != t1[i].a));
`endif
      end
      v1 = 1'b0;

      // WIDTH=8 vectors back to back.
      for (int i = 0; i < 7; i++) begin
         apply8(t8[i].a, t8[i].b, 1'b1);
         chk8($sformatf("tt8[%0d]", i), t8[i], 1'b1);
      end

      // Hold: capture 3,1 then present new operands with in_valid low.
      e = '{a:8'd3, b:8'd1, w:8'd4, x:1'b0, y:8'd2, z:1'b0, oa:1'b0, os:1'b0};
      apply8(8'd3, 8'd1, 1'b1);
      chk8("hold_load", e, 1'b1);
      apply8(8'd9, 8'd200, 1'b0);
      chk8("hold_1", e, 1'b0);
      apply8(8'd77, 8'd13, 1'b0);
      chk8("hold_2", e, 1'b0);

      // Async reset between edges with nonzero outputs, then recovery.
      e = '{a:8'd200, b:8'd100, w:8'd44, x:1'b1, y:8'd100, z:1'b0, oa:1'b0, os:1'b1};
      apply8(8'd200, 8'd100, 1'b1);
      chk8("pre_rst", e, 1'b1);
      a8 = 8'd100; b8 = 8'd200;
      #2 rst_n = 1'b0;
      #1;
      e = '{a:8'd0, b:8'd0, w:8'd0, x:1'b0, y:8'd0, z:1'b0, oa:1'b0, os:1'b0};
      chk8("async_rst", e, 1'b0);
      @(posedge clk); #1;
      chk8("rst_held", e, 1'b0);
      rst_n = 1'b1;
      apply8(8'd0, 8'd255, 1'b1);
      chk8("post_rst", t8[6], 1'b1);
      v8 = 1'b0;
      @(posedge clk); #1;
      chk("post_rst.drop_valid", 32'(ov8), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
